// File: rtl/spi_host_cmd_sequencer.sv
// Command sequencer for the SPI host: pops commands, sequences chip-select lead/trail/idle
// timing and issues one byte request at a time to the shift engine.
module spi_host_cmd_sequencer #(
  parameter int unsigned NumCS = 1,
  parameter int unsigned LenW  = 9,
  parameter int unsigned CsW   = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sw_rst_i,

  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LenW-1:0]  cmd_len_i,
  input  logic [1:0]       cmd_dir_i,
  input  logic [1:0]       cmd_speed_i,
  input  logic             cmd_csaat_i,
  input  logic [CsW-1:0]   cmd_csid_i,

  input  logic [3:0]       cfg_csnlead_i,
  input  logic [3:0]       cfg_csntrail_i,
  input  logic [3:0]       cfg_csnidle_i,

  output logic             seg_valid_o,
  input  logic             seg_ready_i,
  output logic [1:0]       seg_dir_o,
  output logic [1:0]       seg_speed_o,
  output logic             seg_last_o,
  input  logic             seg_done_i,

  output logic [NumCS-1:0] csb_o,
  output logic             cmd_done_o,
  output logic             active_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StShift,
    StWaitDone,
    StHeld,
    StTrail,
    StCsIdle
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [LenW-1:0]   rem_q, rem_d;
  logic [1:0]        dir_q, dir_d;
  logic [1:0]        speed_q, speed_d;
  logic              csaat_q, csaat_d;
  logic [CsW-1:0]    csid_q, csid_d;
  logic              pend_q, pend_d;
  logic [NumCS-1:0]  csb_q, csb_d;
  logic              cmd_done_q, cmd_done_d;
  logic              accept;

  // Out-of-range indices match no bit, so every line stays high.
  function automatic logic [NumCS-1:0] cs_mask(input logic [CsW-1:0] id);
    logic [NumCS-1:0] m;
    m = '1;
    for (int unsigned i = 0; i < NumCS; i++) begin
      if (32'(id) == i) m[i] = 1'b0;
    end
    return m;
  endfunction

  assign cmd_ready_o = (state_q == StIdle) || (state_q == StHeld);
  assign accept      = cmd_valid_i & cmd_ready_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dir_d      = dir_q;
    speed_d    = speed_q;
    csaat_d    = csaat_q;
    csid_d     = csid_q;
    pend_d     = pend_q;
    csb_d      = csb_q;
    cmd_done_d = 1'b0;

    if (sw_rst_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      rem_d   = '0;
      dir_d   = '0;
      speed_d = '0;
      csaat_d = 1'b0;
      csid_d  = '0;
      pend_d  = 1'b0;
      csb_d   = '1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            rem_d   = cmd_len_i;
            dir_d   = cmd_dir_i;
            speed_d = cmd_speed_i;
            csaat_d = cmd_csaat_i;
            csid_d  = cmd_csid_i;
            csb_d   = cs_mask(cmd_csid_i);
            cnt_d   = cfg_csnlead_i;
            state_d = StLead;
          end
        end
        StLead: begin
          if (cnt_q == 4'd0) state_d = StShift;
          else               cnt_d   = cnt_q - 4'd1;
        end
        StShift: begin
          if (seg_ready_i) state_d = StWaitDone;
        end
        StWaitDone: begin
          if (seg_done_i) begin
            if (rem_q != '0) begin
              rem_d   = rem_q - LenW'(1);
              state_d = StShift;
            end else begin
              cmd_done_d = 1'b1;
              if (csaat_q) begin
                state_d = StHeld;
              end else begin
                cnt_d   = cfg_csntrail_i;
                state_d = StTrail;
              end
            end
          end
        end
        StHeld: begin
          if (accept) begin
            rem_d   = cmd_len_i;
            dir_d   = cmd_dir_i;
            speed_d = cmd_speed_i;
            csaat_d = cmd_csaat_i;
            csid_d  = cmd_csid_i;
            if (cmd_csid_i == csid_q) begin
              state_d = StShift;
            end else begin
              // csb_q still selects the old device; the new one is asserted after CS idle.
              pend_d  = 1'b1;
              cnt_d   = cfg_csntrail_i;
              state_d = StTrail;
            end
          end
        end
        StTrail: begin
          if (cnt_q == 4'd0) begin
            csb_d   = '1;
            cnt_d   = cfg_csnidle_i;
            state_d = StCsIdle;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StCsIdle: begin
          if (cnt_q == 4'd0) begin
            if (pend_q) begin
              pend_d  = 1'b0;
              csb_d   = cs_mask(csid_q);
              cnt_d   = cfg_csnlead_i;
              state_d = StLead;
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: begin
          csb_d   = '1;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      dir_q      <= '0;
      speed_q    <= '0;
      csaat_q    <= 1'b0;
      csid_q     <= '0;
      pend_q     <= 1'b0;
      csb_q      <= '1;
      cmd_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dir_q      <= dir_d;
      speed_q    <= speed_d;
      csaat_q    <= csaat_d;
      csid_q     <= csid_d;
      pend_q     <= pend_d;
      csb_q      <= csb_d;
      cmd_done_q <= cmd_done_d;
    end
  end

  assign seg_valid_o = (state_q == StShift);
  assign seg_last_o  = (rem_q == '0);
  assign seg_dir_o   = dir_q;
  assign seg_speed_o = speed_q;
  assign csb_o       = csb_q;
  assign cmd_done_o  = cmd_done_q;
  assign active_o    = (state_q != StIdle);

endmodule

// File: tb/tb_spi_host_cmd_sequencer.sv
// Directed bench: a timeline model builds per-cycle stimulus and expected outputs, and a
// negedge compare process checks every cycle; literal checks pin key latencies.
module tb_spi_host_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       sw_rst;
  logic       cmd_valid, cmd_ready;
  logic [8:0] cmd_len;
  logic [1:0] cmd_dir, cmd_speed;
  logic       cmd_csaat;
  logic [1:0] cmd_csid;
  logic [3:0] cfg_lead, cfg_trail, cfg_idle;
  logic       seg_valid, seg_ready, seg_last, seg_done;
  logic [1:0] seg_dir, seg_speed;
  logic [1:0] csb;
  logic       cmd_done, active;

  always #5 clk = ~clk;

  spi_host_cmd_sequencer #(
    .NumCS(2),
    .LenW (9),
    .CsW  (2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .sw_rst_i      (sw_rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_len_i     (cmd_len),
    .cmd_dir_i     (cmd_dir),
    .cmd_speed_i   (cmd_speed),
    .cmd_csaat_i   (cmd_csaat),
    .cmd_csid_i    (cmd_csid),
    .cfg_csnlead_i (cfg_lead),
    .cfg_csntrail_i(cfg_trail),
    .cfg_csnidle_i (cfg_idle),
    .seg_valid_o   (seg_valid),
    .seg_ready_i   (seg_ready),
    .seg_dir_o     (seg_dir),
    .seg_speed_o   (seg_speed),
    .seg_last_o    (seg_last),
    .seg_done_i    (seg_done),
    .csb_o         (csb),
    .cmd_done_o    (cmd_done),
    .active_o      (active)
  );

  typedef struct {
    logic       cmd_valid;
    logic [8:0] len;
    logic [1:0] dir, speed;
    logic       csaat;
    logic [1:0] csid;
    logic [3:0] lead, trail, idle;
    logic       seg_ready, seg_done, sw_rst;
    logic [1:0] e_csb;
    logic       e_valid, e_last;
    logic [1:0] e_dir, e_speed;
    logic       e_done, e_ready, e_active;
  } vec_t;

  vec_t       q[$];
  vec_t       cur;
  logic       run = 1'b0;
  logic [3:0] cl, ct, ci;
  int         n_tests = 0, n_fail = 0, cyc = 0;
  int         hs_cnt = 0, done_cnt = 0;
  int         cs_first = -1, v_first = -1, sd_first = -1, cd_first = -1;
  int         rise_first = -1, rdy_first = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] mask(input logic [1:0] id);
    logic [1:0] m;
    m = 2'b11;
    if (id < 2'd2) m[id[0]] = 1'b0;
    return m;
  endfunction

  // Idle-state cycle: all CS high, ready, nothing in flight.
  function automatic vec_t base();
    vec_t v;
    v = '{default: '0};
    v.lead = cl; v.trail = ct; v.idle = ci;
    v.e_csb = 2'b11; v.e_ready = 1'b1;
    return v;
  endfunction

  function automatic vec_t busy(input logic [1:0] id);
    vec_t v;
    v = base();
    v.e_ready = 1'b0; v.e_active = 1'b1; v.e_csb = mask(id);
    return v;
  endfunction

  task automatic b_idle(input int n);
    repeat (n) q.push_back(base());
  endtask

  task automatic b_accept(input logic [8:0] len, input logic [1:0] dir, input logic [1:0] spd,
                          input logic csaat, input logic [1:0] id);
    vec_t v;
    v = base();
    v.cmd_valid = 1'b1; v.len = len; v.dir = dir; v.speed = spd; v.csaat = csaat; v.csid = id;
    q.push_back(v);
  endtask

  task automatic b_lead(input logic [1:0] id);
    repeat (int'(cl) + 1) q.push_back(busy(id));
  endtask

  task automatic b_byte(input logic [1:0] id, input logic [1:0] dir, input logic [1:0] spd,
                        input logic last, input int stall, input int dd, input logic done_on_hs,
                        input logic finish);
    vec_t v;
    v = busy(id);
    v.e_valid = 1'b1; v.e_last = last; v.e_dir = dir; v.e_speed = spd;
    repeat (stall) q.push_back(v);
    v.seg_ready = 1'b1; v.seg_done = done_on_hs;
    q.push_back(v);
    repeat (dd) q.push_back(busy(id));
    if (finish) begin
      v = busy(id);
      v.seg_done = 1'b1;
      q.push_back(v);
    end
  endtask

  task automatic b_bytes(input int n, input logic [1:0] id, input logic [1:0] dir,
                         input logic [1:0] spd, input int stall0, input int dd,
                         input logic done_on_hs0);
    for (int b = 0; b < n; b++)
      b_byte(id, dir, spd, b == n - 1, (b == 0) ? stall0 : 0, dd, (b == 0) && done_on_hs0, 1'b1);
  endtask

  task automatic b_trail(input logic [1:0] id, input logic done_first);
    vec_t v;
    for (int j = 0; j <= int'(ct); j++) begin
      v = busy(id);
      v.e_done = (j == 0) && done_first;
      q.push_back(v);
    end
    repeat (int'(ci) + 1) q.push_back(busy(2'd3));
  endtask

  task automatic b_held(input logic [1:0] id, input int n, input logic [8:0] len,
                        input logic [1:0] dir, input logic [1:0] spd, input logic csaat,
                        input logic [1:0] nid);
    vec_t v;
    for (int j = 0; j < n; j++) begin
      v = busy(id);
      v.e_ready = 1'b1; v.e_done = (j == 0);
      if (j == n - 1) begin
        v.cmd_valid = 1'b1; v.len = len; v.dir = dir; v.speed = spd; v.csaat = csaat;
        v.csid = nid;
      end
      q.push_back(v);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      cyc++;
      chk("csb", 32'(csb), 32'(cur.e_csb));
      chk("seg_valid", 32'(seg_valid), 32'(cur.e_valid));
      chk("cmd_done", 32'(cmd_done), 32'(cur.e_done));
      chk("cmd_ready", 32'(cmd_ready), 32'(cur.e_ready));
      chk("active", 32'(active), 32'(cur.e_active));
      if (cur.e_valid) begin
        chk("seg_last", 32'(seg_last), 32'(cur.e_last));
        chk("seg_dir", 32'(seg_dir), 32'(cur.e_dir));
        chk("seg_speed", 32'(seg_speed), 32'(cur.e_speed));
      end
      if (seg_valid && seg_ready) hs_cnt++;
      if (cmd_done) done_cnt++;
      if (cs_first < 0 && csb[0] == 1'b0) cs_first = cyc;
      if (v_first < 0 && seg_valid) v_first = cyc;
      if (sd_first < 0 && seg_done) sd_first = cyc;
      if (cd_first < 0 && cmd_done) cd_first = cyc;
      if (cd_first >= 0 && rise_first < 0 && csb == 2'b11) rise_first = cyc;
      if (rise_first >= 0 && rdy_first < 0 && cmd_ready) rdy_first = cyc;
    end
  end

  initial begin
    rst_ni = 1'b0; sw_rst = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_dir = '0;
    cmd_speed = '0; cmd_csaat = 1'b0; cmd_csid = '0; cfg_lead = '0; cfg_trail = '0;
    cfg_idle = '0; seg_ready = 1'b0; seg_done = 1'b0;

    // T1: single tx byte, lead 1, trail 2, idle 3
    cl = 4'd1; ct = 4'd2; ci = 4'd3;
    b_idle(2);
    b_accept(9'd0, 2'd2, 2'd0, 1'b0, 2'd0);
    b_lead(2'd0);
    b_bytes(1, 2'd0, 2'd2, 2'd0, 0, 1, 1'b0);
    b_trail(2'd0, 1'b1);
    b_idle(2);
    // T2: four rx bytes on cs1, first request stalled, done with handshake not credited
    b_accept(9'd3, 2'd1, 2'd2, 1'b0, 2'd1);
    b_lead(2'd1);
    b_bytes(4, 2'd1, 2'd1, 2'd2, 5, 0, 1'b1);
    b_trail(2'd1, 1'b1);
    b_idle(1);
    // T3: held CS, same device, zero-length timing
    cl = 4'd0; ct = 4'd0; ci = 4'd0;
    b_accept(9'd1, 2'd3, 2'd1, 1'b1, 2'd0);
    b_lead(2'd0);
    b_bytes(2, 2'd0, 2'd3, 2'd1, 0, 2, 1'b0);
    b_held(2'd0, 2, 9'd0, 2'd2, 2'd0, 1'b0, 2'd0);
    b_bytes(1, 2'd0, 2'd2, 2'd0, 0, 0, 1'b0);
    b_trail(2'd0, 1'b1);
    b_idle(1);
    // T4: held CS, switch to the other device
    cl = 4'd2; ct = 4'd1; ci = 4'd2;
    b_accept(9'd0, 2'd2, 2'd0, 1'b1, 2'd0);
    b_lead(2'd0);
    b_bytes(1, 2'd0, 2'd2, 2'd0, 0, 1, 1'b0);
    b_held(2'd0, 1, 9'd1, 2'd1, 2'd1, 1'b0, 2'd1);
    b_trail(2'd0, 1'b0);
    b_lead(2'd1);
    b_bytes(2, 2'd1, 2'd1, 2'd1, 1, 1, 1'b0);
    b_trail(2'd1, 1'b1);
    b_idle(1);
    // T5: csid beyond NumCS leaves every CS line high
    b_accept(9'd1, 2'd0, 2'd0, 1'b0, 2'd3);
    b_lead(2'd3);
    b_bytes(2, 2'd3, 2'd0, 2'd0, 0, 0, 1'b0);
    b_trail(2'd3, 1'b1);
    b_idle(1);
    // T6: soft reset while the third byte of eight is in flight, then a stray done
    begin
      vec_t v;
      b_accept(9'd7, 2'd2, 2'd1, 1'b0, 2'd0);
      b_lead(2'd0);
      b_byte(2'd0, 2'd2, 2'd1, 1'b0, 0, 0, 1'b0, 1'b1);
      b_byte(2'd0, 2'd2, 2'd1, 1'b0, 0, 0, 1'b0, 1'b1);
      b_byte(2'd0, 2'd2, 2'd1, 1'b0, 0, 1, 1'b0, 1'b0);
      v = busy(2'd0);
      v.sw_rst = 1'b1;
      q.push_back(v);
      v = base();
      v.seg_done = 1'b1;
      q.push_back(v);
      b_idle(3);
    end

    repeat (2) @(negedge clk);
    chk("rst_csb", 32'(csb), 32'h3);
    chk("rst_valid", 32'(seg_valid), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_done", 32'(cmd_done), 32'h0);
    @(posedge clk); #1 rst_ni = 1'b1;

    foreach (q[i]) begin
      @(posedge clk); #1;
      cmd_valid = q[i].cmd_valid; cmd_len = q[i].len; cmd_dir = q[i].dir;
      cmd_speed = q[i].speed; cmd_csaat = q[i].csaat; cmd_csid = q[i].csid;
      cfg_lead = q[i].lead; cfg_trail = q[i].trail; cfg_idle = q[i].idle;
      seg_ready = q[i].seg_ready; seg_done = q[i].seg_done; sw_rst = q[i].sw_rst;
      cur = q[i];
      run = 1'b1;
    end
    @(posedge clk); #1;
    run = 1'b0; cmd_valid = 1'b0; seg_ready = 1'b0; seg_done = 1'b0; sw_rst = 1'b0;

    chk("t1_lead_to_valid", 32'(v_first - cs_first), 32'd2);
    chk("t1_done_latency", 32'(cd_first - sd_first), 32'd1);
    chk("t1_trail_len", 32'(rise_first - cd_first), 32'd3);
    chk("t1_idle_len", 32'(rdy_first - rise_first), 32'd4);
    chk("handshakes", 32'(hs_cnt), 32'd16);
    chk("cmd_done_pulses", 32'(done_cnt), 32'd7);

    // T7: asynchronous reset in the middle of a long lead
    cfg_lead = 4'd3; cmd_csid = 2'd0; cmd_len = 9'd0; cmd_csaat = 1'b0;
    @(posedge clk); #1 cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("lead_csb", 32'(csb), 32'h2);
    chk("lead_active", 32'(active), 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_csb", 32'(csb), 32'h3);
    chk("arst_valid", 32'(seg_valid), 32'h0);
    chk("arst_ready", 32'(cmd_ready), 32'h1);
    chk("arst_active", 32'(active), 32'h0);
    @(posedge clk); #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_arst_ready", 32'(cmd_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
